ec_gen_error_pipe: RTL and testbench

//  Parametrised, pipelined error classifier for skip-projection RNS error correction.

---
 rtl/ec_gen_error_pipe.sv | 170 +++++++++++++++++
 tb/tb_ec_gen_error_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ec_gen_error_pipe.sv
// ec_gen_error_pipe
//   Pipelined error classifier for skip-projection RNS error correction.
//   Each digit supplies the sign pair (A,B) of its skip projection. A word is
//   classified as OK, correctable (single consistent projection, index
//   reported), uncorrectable, or malfunction (illegal sign code seen).
//   Latency is $clog2(NUM_DIGITS)+2 cycles, one word per cycle, no backpressure.
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid            sign inputs valid this cycle
//   sign_A, sign_B      digit i sign at [2i+1:2i]
//   clr_cnt             synchronous clear of the event counters
//   out_valid           classification valid
//   out_ok/out_corr/out_uncor/out_malf   one-hot class when out_valid
//   err_idx             faulty digit index when out_corr, else 0
//   cnt_corr/cnt_uncor/cnt_malf          saturating event counters

// Per-digit sign compare.
module ec_digit_cmp #(
    parameter logic [1:0] MALF_CODE = 2'b11
) (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       mis,
    output logic       malf
);
    assign mis  = (a != b);
    assign malf = (a == MALF_CODE) | (b == MALF_CODE);
endmodule

module ec_gen_error_pipe #(
    parameter int         NUM_DIGITS = 10,
    parameter int         CNT_W      = 16,
    parameter logic [1:0] MALF_CODE  = 2'b11,
    localparam int        IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [2*NUM_DIGITS-1:0] sign_A,
    input  logic [2*NUM_DIGITS-1:0] sign_B,
    input  logic                    clr_cnt,
    output logic                    out_valid,
    output logic                    out_ok,
    output logic                    out_corr,
    output logic [IDX_W-1:0]        err_idx,
    output logic                    out_uncor,
    output logic                    out_malf,
    output logic [CNT_W-1:0]        cnt_corr,
    output logic [CNT_W-1:0]        cnt_uncor,
    output logic [CNT_W-1:0]        cnt_malf
);
    localparam int LVL = IDX_W;       // reduction stages
    localparam int P   = 1 << LVL;    // leaves after padding to a power of two

    // Reduction node. found/multi/idx track consistent (non-mismatched) digits,
    // lowest index wins.
    typedef struct packed {
        logic             any_mis;
        logic             all_mis;
        logic             malf;
        logic             found;
        logic             multi;
        logic [IDX_W-1:0] idx;
    } node_t;

    function automatic node_t combine(input node_t l, input node_t r);
        node_t n;
        n.any_mis = l.any_mis | r.any_mis;
        n.all_mis = l.all_mis & r.all_mis;
        n.malf    = l.malf | r.malf;
        n.found   = l.found | r.found;
        n.multi   = (l.found & r.found) | l.multi | r.multi;
        n.idx     = l.found ? l.idx : r.idx;
        return n;
    endfunction

    logic [NUM_DIGITS-1:0] mis, malf;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        ec_digit_cmp #(.MALF_CODE(MALF_CODE)) u_cmp (
            .a    (sign_A[2*i +: 2]),
            .b    (sign_B[2*i +: 2]),
            .mis  (mis[i]),
            .malf (malf[i])
        );
    end

    // Pad leaves: identity elements (no mismatch for OR, mismatch for AND,
    // never found) so padding cannot change the result.
    logic [P-1:0] mis_pad, malf_pad, real_pad;
    node_t        leaf_n [P];

    always_comb begin
        mis_pad  = '0;
        malf_pad = '0;
        real_pad = '0;
        mis_pad[NUM_DIGITS-1:0]  = mis;
        malf_pad[NUM_DIGITS-1:0] = malf;
        real_pad[NUM_DIGITS-1:0] = '1;
        for (int i = 0; i < P; i++) begin
            leaf_n[i].any_mis = mis_pad[i];
            leaf_n[i].all_mis = mis_pad[i] | ~real_pad[i];
            leaf_n[i].malf    = malf_pad[i];
            leaf_n[i].found   = real_pad[i] & ~mis_pad[i];
            leaf_n[i].multi   = 1'b0;
            leaf_n[i].idx     = IDX_W'(i);
        end
    end

    // Heap-ordered tree: leaves at [P..2P-1] form stage 0, node j feeds from
    // 2j/2j+1, so each level is one register stage and the root is tree[1].
    node_t tree [1:2*P-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < P; i++) tree[P+i] <= leaf_n[i];
        for (int j = 1; j < P; j++) tree[j] <= combine(tree[2*j], tree[2*j+1]);
    end

    logic [LVL:0] vld_pipe;

    always_ff @(posedge clk) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[LVL-1:0], in_valid};
    end

    node_t root;
    logic  v, malf_c, uncor_c, ok_c, corr_c;

    always_comb begin
        root    = tree[1];
        v       = vld_pipe[LVL];
        malf_c  = v & root.malf;
        ok_c    = v & ~root.malf & ~root.any_mis;
        corr_c  = v & ~root.malf & ~root.all_mis & root.any_mis & root.found & ~root.multi;
        uncor_c = v & ~malf_c & ~ok_c & ~corr_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ok    <= 1'b0;
            out_corr  <= 1'b0;
            out_uncor <= 1'b0;
            out_malf  <= 1'b0;
            err_idx   <= '0;
        end else begin
            out_valid <= v;
            out_ok    <= ok_c;
            out_corr  <= corr_c;
            out_uncor <= uncor_c;
            out_malf  <= malf_c;
            err_idx   <= corr_c ? root.idx : '0;
        end
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Clear wins over a same-cycle event; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            cnt_corr  <= '0;
            cnt_uncor <= '0;
            cnt_malf  <= '0;
        end else begin
            if (out_valid && out_corr  && cnt_corr  != CNT_MAX) cnt_corr  <= cnt_corr  + 1'b1;
            if (out_valid && out_uncor && cnt_uncor != CNT_MAX) cnt_uncor <= cnt_uncor + 1'b1;
            if (out_valid && out_malf  && cnt_malf  != CNT_MAX) cnt_malf  <= cnt_malf  + 1'b1;
        end
    end
endmodule

// File: tb/tb_ec_gen_error_pipe.sv
module tb_ec_gen_error_pipe;
    localparam int N = 10;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, clr_cnt;
    logic [2*N-1:0] sign_A, sign_B;
    logic          out_valid, out_ok, out_corr, out_uncor, out_malf;
    logic [3:0]    err_idx;
    logic [CW-1:0] cnt_corr, cnt_uncor, cnt_malf;
    logic [4:0]    flags;

    int tests = 0;
    int fails = 0;

    ec_gen_error_pipe #(.NUM_DIGITS(N), .CNT_W(CW), .MALF_CODE(2'b11)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .sign_A(sign_A), .sign_B(sign_B), .clr_cnt(clr_cnt),
        .out_valid(out_valid), .out_ok(out_ok), .out_corr(out_corr),
        .err_idx(err_idx), .out_uncor(out_uncor), .out_malf(out_malf),
        .cnt_corr(cnt_corr), .cnt_uncor(cnt_uncor), .cnt_malf(cnt_malf)
    );

    always #5 clk = ~clk;

    // {valid, ok, corr, uncor, malf}
    assign flags = {out_valid, out_ok, out_corr, out_uncor, out_malf};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Legal sign A per digit: i%3, never 2'b11.
    function automatic logic [2*N-1:0] mk_a();
        logic [2*N-1:0] a;
        for (int i = 0; i < N; i++) a[2*i +: 2] = 2'(i % 3);
        return a;
    endfunction

    // Sign B: equal to A where cons[i]=1, otherwise a different legal code.
    function automatic logic [2*N-1:0] mk_b(input logic [N-1:0] cons);
        logic [2*N-1:0] b;
        logic [1:0] ai;
        for (int i = 0; i < N; i++) begin
            ai = 2'(i % 3);
            b[2*i +: 2] = cons[i] ? ai : ((ai == 2'd0) ? 2'd1 : 2'd0);
        end
        return b;
    endfunction

    // Drive one word; returns right after the edge where its result appears.
    task automatic send(input logic [2*N-1:0] a, input logic [2*N-1:0] b);
        sign_A = a; sign_B = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
    endtask

    task automatic pulse_clr();
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0; sign_A = '0; sign_B = '0;
        repeat (3) tick();
        tests++;
        if (flags !== 5'b0 || err_idx !== 4'd0) begin
            fails++; $display("FAIL reset_flags: got %b idx %0d, want 00000 idx 0", flags, err_idx);
        end
        tests++;
        if (cnt_corr !== 0 || cnt_uncor !== 0 || cnt_malf !== 0) begin
            fails++; $display("FAIL reset_cnt: got %0d/%0d/%0d, want 0/0/0", cnt_corr, cnt_uncor, cnt_malf);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ok();
        send('0, '0);
        tests++;
        if (flags !== 5'b11000 || err_idx !== 4'd0) begin
            fails++; $display("FAIL ok_word: got %b idx %0d, want 11000 idx 0", flags, err_idx);
        end
        tick();
        tests++;
        if (flags !== 5'b0 || cnt_corr !== 0 || cnt_uncor !== 0 || cnt_malf !== 0) begin
            fails++; $display("FAIL ok_after: got %b cnt %0d/%0d/%0d, want 00000 cnt 0/0/0",
                              flags, cnt_corr, cnt_uncor, cnt_malf);
        end
    endtask

    task automatic test_corr();
        logic [N-1:0] cons [3] = '{10'b0010000000, 10'b0000000001, 10'b1000000000};
        logic [3:0]   eidx [3] = '{4'd7, 4'd0, 4'd9};
        pulse_clr();
        for (int t = 0; t < 3; t++) begin
            send(mk_a(), mk_b(cons[t]));
            tests++;
            if (flags !== 5'b10100 || err_idx !== eidx[t]) begin
                fails++; $display("FAIL corr_%0d: got %b idx %0d, want 10100 idx %0d", t, flags, err_idx, eidx[t]);
            end
            tick();
            tests++;
            if (cnt_corr !== CW'(t + 1)) begin
                fails++; $display("FAIL corr_cnt_%0d: got %0d, want %0d", t, cnt_corr, t + 1);
            end
        end
    endtask

    task automatic test_uncor();
        pulse_clr();
        send(mk_a(), mk_b(10'b0));
        tests++;
        if (flags !== 5'b10010 || err_idx !== 4'd0) begin
            fails++; $display("FAIL uncor_all: got %b idx %0d, want 10010 idx 0", flags, err_idx);
        end
        send(mk_a(), mk_b(10'b0000100100));
        tests++;
        if (flags !== 5'b10010 || err_idx !== 4'd0) begin
            fails++; $display("FAIL uncor_ambig: got %b idx %0d, want 10010 idx 0", flags, err_idx);
        end
        tick();
        tests++;
        if (cnt_uncor !== 4'd2 || cnt_corr !== 4'd0) begin
            fails++; $display("FAIL uncor_cnt: got %0d/%0d, want uncor 2 corr 0", cnt_uncor, cnt_corr);
        end
    endtask

    task automatic test_malf();
        logic [2*N-1:0] a;
        pulse_clr();
        a = mk_a();
        a[9:8] = 2'b11;
        send(a, mk_b(10'b0));
        tests++;
        if (flags !== 5'b10001 || err_idx !== 4'd0) begin
            fails++; $display("FAIL malf_word: got %b idx %0d, want 10001 idx 0", flags, err_idx);
        end
        tick();
        tests++;
        if (cnt_malf !== 4'd1 || cnt_uncor !== 4'd0) begin
            fails++; $display("FAIL malf_cnt: got malf %0d uncor %0d, want 1/0", cnt_malf, cnt_uncor);
        end
    endtask

    task automatic test_back_to_back();
        int n_corr = 0;
        int bad = 0;
        logic exp;
        pulse_clr();
        for (int k = 1; k <= 27; k++) begin
            if (k <= 20) begin
                sign_A = mk_a(); sign_B = mk_b(10'b0000001000); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            exp = (k >= 6 && k <= 25);
            if (out_corr === 1'b1) n_corr++;
            if (out_corr !== exp || out_valid !== exp || (exp && err_idx !== 4'd3)) bad++;
        end
        tests++;
        if (bad != 0 || n_corr != 20) begin
            fails++; $display("FAIL b2b_stream: got %0d corr with %0d bad cycles, want 20 and 0", n_corr, bad);
        end
        tests++;
        if (cnt_corr !== 4'd15) begin
            fails++; $display("FAIL b2b_sat: got %0d, want 15", cnt_corr);
        end
        // Clear on the same cycle as an out_corr event: clear wins.
        send(mk_a(), mk_b(10'b0000001000));
        tests++;
        if (out_corr !== 1'b1) begin
            fails++; $display("FAIL clr_setup: got out_corr %b, want 1", out_corr);
        end
        pulse_clr();
        tests++;
        if (cnt_corr !== 4'd0) begin
            fails++; $display("FAIL clr_prio: got %0d, want 0", cnt_corr);
        end
        tick();
        tests++;
        if (cnt_corr !== 4'd0) begin
            fails++; $display("FAIL clr_hold: got %0d, want 0", cnt_corr);
        end
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        logic [2*N-1:0] a;
        a = mk_a();
        a[1:0] = 2'b11;
        send(a, mk_b(10'b0));
        tick();
        tests++;
        if (cnt_malf !== 4'd1) begin
            fails++; $display("FAIL mrst_setup: got cnt_malf %0d, want 1", cnt_malf);
        end
        sign_A = mk_a(); sign_B = mk_b(10'b0000010000); in_valid = 1'b1;
        tick();
        sign_B = mk_b(10'b0);
        tick();
        sign_B = mk_b(10'b0100000000); rst_n = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        tests++;
        if (flags !== 5'b0 || cnt_corr !== 0 || cnt_uncor !== 0 || cnt_malf !== 0) begin
            fails++; $display("FAIL mrst_clear: got %b cnt %0d/%0d/%0d, want 00000 cnt 0/0/0",
                              flags, cnt_corr, cnt_uncor, cnt_malf);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++; $display("FAIL mrst_flush: got %0d valid cycles, want 0", seen);
        end
        sign_A = mk_a(); sign_B = mk_b(10'b0000100000); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL mrst_early: got out_valid %b one cycle early, want 0", out_valid);
        end
        tick();
        tests++;
        if (flags !== 5'b10100 || err_idx !== 4'd5) begin
            fails++; $display("FAIL mrst_word: got %b idx %0d, want 10100 idx 5", flags, err_idx);
        end
    endtask

    initial begin
        test_reset();
        test_ok();
        test_corr();
        test_uncor();
        test_malf();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
